result_drain: RTL

//  Output end of the 2x2 tensor-core datapath: the operand streamer feeds int8 operands in, and this

---
 rtl/tc_pkg.sv | 43 ++++
 rtl/result_drain.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tc_pkg.sv
// ============================================================================
//  Module  : tc_pkg
//  Brief   : Shared types, constants and the signed-16 saturation helper for
//            the 2x2 tensor-core result drain. Honours SAT16_PACK_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tc_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BLK = 2'd1,
      SEND     = 2'd2,
      DONE     = 2'd3
   } drain_state_t;

`ifdef SAT16_PACK_EN
   localparam int WORDS_PER_TILE = 2;
`else
   localparam int WORDS_PER_TILE = 4;
`endif

   // Wide enough for any accumulator width the drain is built with.
   localparam int SAT_IN_W = 64;

   localparam logic signed [SAT_IN_W-1:0] SAT16_MAX = 64'sd32767;
   localparam logic signed [SAT_IN_W-1:0] SAT16_MIN = -64'sd32768;

   function automatic logic [15:0] sat16(input logic signed [SAT_IN_W-1:0] v);
      logic [15:0] r;
      if (v > SAT16_MAX)
         r = 16'h7FFF;
      else if (v < SAT16_MIN)
         r = 16'h8000;
      else
         r = v[15:0];
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/result_drain.sv
// ============================================================================
//  Module  : result_drain
//  Brief   : Captures the four PE accumulators per 2x2 tile, pulses acc_clear
//            and streams the results as 32-bit words over valid/ready.
//            Build option SAT16_PACK_EN: saturate to int16, pack two per word.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module result_drain
   import tc_pkg::*;
#(
   parameter int ACC_W  = 32,
   parameter int SIZE_W = 17,
   parameter int BUS_W  = 32
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [SIZE_W-1:0]       size,
   input  logic                    start,
   input  logic                    blk_valid,
   output logic                    blk_ready,
   input  logic signed [ACC_W-1:0] c11,
   input  logic signed [ACC_W-1:0] c12,
   input  logic signed [ACC_W-1:0] c21,
   input  logic signed [ACC_W-1:0] c22,
   output logic                    acc_clear,
   output logic [BUS_W-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    done
);

   localparam logic [1:0] c_LAST_IDX = 2'(WORDS_PER_TILE - 1);

   drain_state_t            r_state;
   drain_state_t            w_next_state;
   logic [31:0]             r_tiles;
   logic [31:0]             r_tile_cnt;
   logic [1:0]              r_idx;
   logic                    r_acc_clear;
   logic signed [ACC_W-1:0] r_h11;
   logic signed [ACC_W-1:0] r_h12;
   logic signed [ACC_W-1:0] r_h21;
   logic signed [ACC_W-1:0] r_h22;

   logic [SIZE_W-1:0]       w_half;
   logic [31:0]             w_tile_total;
   logic                    w_capture;
   logic                    w_hs;
   logic                    w_last_word;
   logic                    w_last_tile;
   logic [31:0]             w_word;

   // Odd sizes drop their last row/column: size[0] is shifted away.
   assign w_half       = size >> 1;
   assign w_tile_total = 32'(w_half) * 32'(w_half);

   assign w_capture   = (r_state == WAIT_BLK) && blk_valid;
   assign w_hs        = (r_state == SEND) && out_ready;
   assign w_last_word = (r_idx == c_LAST_IDX);
   assign w_last_tile = (r_tile_cnt == r_tiles - 32'd1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (start) w_next_state = (w_tile_total == 32'd0) ? DONE : WAIT_BLK;
         WAIT_BLK: if (blk_valid) w_next_state = SEND;
         SEND:     if (out_ready && w_last_word) w_next_state = w_last_tile ? DONE : WAIT_BLK;
         DONE:     w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tiles     <= '0;
         r_tile_cnt  <= '0;
         r_idx       <= '0;
         r_acc_clear <= 1'b0;
         r_h11       <= '0;
         r_h12       <= '0;
         r_h21       <= '0;
         r_h22       <= '0;
      end else begin
         r_acc_clear <= w_capture;
         if ((r_state == IDLE) && start) begin
            r_tiles    <= w_tile_total;
            r_tile_cnt <= '0;
         end
         if (w_capture) begin
            r_h11 <= c11;
            r_h12 <= c12;
            r_h21 <= c21;
            r_h22 <= c22;
            r_idx <= '0;
         end
         if (w_hs) begin
            if (w_last_word) begin
               r_idx      <= '0;
               r_tile_cnt <= w_last_tile ? 32'd0 : r_tile_cnt + 32'd1;
            end else begin
               r_idx <= r_idx + 2'd1;
            end
         end
      end
   end

   // Word mux reads only holding registers, so data is stable across stalls.
   always_comb begin
      w_word = '0;
      if (r_state == SEND) begin
`ifdef SAT16_PACK_EN
         case (r_idx)
            2'd0:    w_word = {sat16(SAT_IN_W'(r_h12)), sat16(SAT_IN_W'(r_h11))};
            default: w_word = {sat16(SAT_IN_W'(r_h22)), sat16(SAT_IN_W'(r_h21))};
         endcase
`else
         case (r_idx)
            2'd0:    w_word = 32'(r_h11);
            2'd1:    w_word = 32'(r_h12);
            2'd2:    w_word = 32'(r_h21);
            default: w_word = 32'(r_h22);
         endcase
`endif
      end
   end

   assign out_data  = BUS_W'(w_word);
   assign out_valid = (r_state == SEND);
   assign blk_ready = (r_state == WAIT_BLK);
   assign acc_clear = r_acc_clear;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);

endmodule

`default_nettype wire
